// File: rtl/led_pkg.sv
// Shared mode codes, scan direction type and init-pattern helper for the LED sequencer.
package led_pkg;

    localparam logic [1:0] MODE_BLINK = 2'b00;
    localparam logic [1:0] MODE_COUNT = 2'b01;
    localparam logic [1:0] MODE_SCAN  = 2'b10;
    localparam logic [1:0] MODE_CHASE = 2'b11;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    // LSB of the pattern a mode starts from; every other bit of the init pattern is zero.
    // SCAN and CHASE start with a single lit LED at bit 0, BLINK and COUNT start dark.
    function automatic logic init_lsb(input logic [1:0] mode);
        return (mode == MODE_SCAN) || (mode == MODE_CHASE);
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_tick_prescaler.sv
// Clock-enable prescaler: counts 0..DIV-1 and flags the last count as a step tick.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    input  logic HOLD,
    output logic TICK
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Step counter: cleared by reset or mode change, frozen while held, wraps after LAST.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (CLR) begin
            count <= '0;
        end else if (!HOLD) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    // A tick is only issued when the counter is actually allowed to wrap this cycle.
    assign TICK = (count == LAST) && !HOLD;

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: mode register, scan-direction FSM and registered LED/STEP outputs.
module led_pattern_sequencer
    import led_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int STEP_HZ = 4,
    parameter int WIDTH   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       MODE,
    input  logic             PAUSE,
    output logic [WIDTH-1:0] LED,
    output logic             STEP
);

    localparam int DIV = CLK_HZ / STEP_HZ;

    logic [1:0]       mode_q;
    dir_t             dir_q;
    dir_t             dir_next;
    logic [WIDTH-1:0] led_next;
    logic [WIDTH-1:0] init_cur;
    logic [WIDTH-1:0] init_new;
    logic             mode_change;
    logic             tick;

    assign mode_change = (MODE != mode_q);
    assign init_cur    = {{(WIDTH-1){1'b0}}, init_lsb(mode_q)};
    assign init_new    = {{(WIDTH-1){1'b0}}, init_lsb(MODE)};

    // A mode change restarts the step interval so the new pattern gets a full first step.
    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (mode_change),
        .HOLD (PAUSE),
        .TICK (tick)
    );

    // Next pattern value and scan direction for the current mode, used only on a tick.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned, which would infer a latch.
        led_next = LED;
        dir_next = dir_q;
        case (mode_q)
            MODE_BLINK: led_next = ~LED;
            MODE_COUNT: led_next = LED + 1'b1;
            MODE_SCAN: begin
                if (LED == '0) begin
                    led_next = init_cur;
                    dir_next = DIR_LEFT;
                end else if (dir_q == DIR_LEFT) begin
                    led_next = LED << 1;
                    if (led_next[WIDTH-1]) begin
                        dir_next = DIR_RIGHT;
                    end
                end else begin
                    led_next = LED >> 1;
                    if (led_next == WIDTH'(1)) begin
                        dir_next = DIR_LEFT;
                    end
                end
            end
            MODE_CHASE: begin
                if (LED == '0) begin
                    led_next = init_cur;
                end else begin
                    led_next = {LED[WIDTH-2:0], LED[WIDTH-1]};
                end
            end
            default: ;
        endcase
    end

    // Output and state registers: reset beats mode change, mode change beats a coincident tick.
    always_ff @(posedge CLK) begin
        if (RST) begin
            LED    <= '0;
            STEP   <= 1'b0;
            mode_q <= MODE_BLINK;
            dir_q  <= DIR_LEFT;
        end else if (mode_change) begin
            mode_q <= MODE;
            LED    <= init_new;
            dir_q  <= DIR_LEFT;
            STEP   <= 1'b0;
        end else if (tick) begin
            LED    <= led_next;
            dir_q  <= dir_next;
            STEP   <= 1'b1;
        end else begin
            STEP   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench: step-level reference model predicts each STEP pulse and LED value.
module tb_led_pattern_sequencer;

    localparam int CLK_HZ  = 8;
    localparam int STEP_HZ = 2;
    localparam int W       = 8;
    localparam int DIV     = CLK_HZ / STEP_HZ;

    typedef struct {
        int         cyc;
        logic [7:0] led;
    } step_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   mode;
    logic         pause;
    logic [W-1:0] led;
    logic         step;

    int           checks = 0;
    int           errors = 0;
    int           cyc    = 0;
    step_t        sb[$];

    // Reference model: mode register, active cycles and steps since the last pattern load.
    logic [1:0]   m_mode;
    int           m_active;
    int           m_steps;
    logic [7:0]   exp_led;

    led_pattern_sequencer #(
        .CLK_HZ  (CLK_HZ),
        .STEP_HZ (STEP_HZ),
        .WIDTH   (W)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .MODE  (mode),
        .PAUSE (pause),
        .LED   (led),
        .STEP  (step)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Pattern shown after n steps in a mode, written in closed form.
    function automatic logic [7:0] pattern(input logic [1:0] md, input int n);
        int p;
        int pos;
        case (md)
            2'b00: return (n % 2 == 1) ? 8'hFF : 8'h00;
            2'b01: return 8'(n % 256);
            2'b10: begin
                p   = n % (2 * W - 2);
                pos = (p < W) ? p : (2 * W - 2 - p);
                return 8'(1 << pos);
            end
            default: return 8'(1 << (n % W));
        endcase
    endfunction

    // Apply inputs for one clock, advance the model on the edge, push any predicted step.
    task automatic cycle(input logic r, input logic [1:0] m, input logic p);
        step_t e;
        rst   = r;
        mode  = m;
        pause = p;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_mode   = 2'b00;
            m_active = 0;
            m_steps  = 0;
        end else if (m != m_mode) begin
            m_mode   = m;
            m_active = 0;
            m_steps  = 0;
        end else if (!p) begin
            m_active++;
            if (m_active % DIV == 0) begin
                m_steps++;
                e.cyc = cyc;
                e.led = pattern(m_mode, m_steps);
                sb.push_back(e);
            end
        end
        exp_led = pattern(m_mode, m_steps);
        @(negedge clk);
    endtask

    // Monitor: every cycle compares LED, and pops the scoreboard when a step is due.
    initial begin
        step_t e;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                check("led_level", 32'(led), 32'(exp_led));
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    e = sb.pop_front();
                    check("step_pulse", 32'(step), 32'd1);
                    check("step_led", 32'(led), 32'(e.led));
                end else begin
                    check("step_idle", 32'(step), 32'd0);
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       r;
        logic [1:0] m;
        logic       p;

        // Count mode from reset, long enough to see FF wrap to 00.
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'b01, 1'b0);
        for (int i = 0; i < 256 * DIV + 12; i++) cycle(1'b0, 2'b01, 1'b0);

        // Scan from reset through two full bounce periods.
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 2 * (2 * W - 2) * DIV + 8; i++) cycle(1'b0, 2'b10, 1'b0);

        // Chase through a full rotation, then blink.
        for (int i = 0; i < (W + 2) * DIV; i++) cycle(1'b0, 2'b11, 1'b0);
        for (int i = 0; i < 5 * DIV; i++) cycle(1'b0, 2'b00, 1'b0);

        // Pause for 10 cycles with the prescaler at 2, then release.
        for (int i = 0; i < 3 * DIV; i++) cycle(1'b0, 2'b01, 1'b0);
        for (int k = 0; k < 2 * DIV && (m_active % DIV) != 2; k++) cycle(1'b0, 2'b01, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 2'b01, 1'b1);
        for (int i = 0; i < 3 * DIV; i++) cycle(1'b0, 2'b01, 1'b0);

        // Mode change exactly when the prescaler is at its last count.
        for (int k = 0; k < 2 * DIV && (m_active % DIV) != DIV - 1; k++) cycle(1'b0, 2'b01, 1'b0);
        for (int i = 0; i < 3 * DIV; i++) cycle(1'b0, 2'b11, 1'b0);

        // Mode change while paused, then release.
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'b10, 1'b1);
        for (int i = 0; i < 2 * DIV; i++) cycle(1'b0, 2'b10, 1'b0);

        // Reset in mid-scan while moving right at LED=20, MODE held at SCAN.
        for (int k = 0; k < 4 * (2 * W - 2) * DIV && (m_steps % (2 * W - 2)) != 9; k++) begin
            cycle(1'b0, 2'b10, 1'b0);
        end
        cycle(1'b1, 2'b10, 1'b0);
        for (int i = 0; i < (2 * W) * DIV; i++) cycle(1'b0, 2'b10, 1'b0);

        // Randomised mix of mode changes, pause bursts and occasional resets.
        m = 2'b10;
        p = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(31) == 0) m = 2'($urandom_range(3));
            if ($urandom_range(7) == 0)  p = ~p;
            r = ($urandom_range(199) == 0);
            cycle(r, m, p);
        end
        for (int i = 0; i < 2 * DIV; i++) cycle(1'b0, m, 1'b0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
